uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame controller behind uart_rx_module.
//  - Unpacks each DEPTH-byte word into a byte stream, element [0] first.
//  - Parses command frames: SYNC, CMD, LEN, LEN payload bytes, CSUM.
//  - Streams the payload to the FFT input side over a valid/ready handshake.
//  - Reports frame completion, checksum errors, timeouts and overruns.
// PARAMETERS
//  DEPTH        4           bytes per rx_data word; must match uart_rx_module
//  SYNC_BYTE    8'hA5       frame start marker
//  TIMEOUT_CYC  2_000_000   max clk cycles between words inside a frame (40 ms @ 50 MHz)
// PORTS
//  clk       in   1          system clock (50 MHz)
//  rst       in   1          reset, synchronous, active-high
//  rx_data   in   DEPTH x 8  packed bytes from uart_rx_module
//  rx_valid  in   1          1-cycle pulse: rx_data holds a new word
//  cmd       out  8          command byte of the current frame
//  len       out  8          payload length of the current frame
//  cmd_valid out  1          1-cycle pulse: cmd and len are updated
//  pl_data   out  8          payload byte
//  pl_valid  out  1          payload byte available
//  pl_ready  in   1          downstream accepts pl_data
//  pl_last   out  1          qualifies the final payload byte
//  frame_ok  out  1          1-cycle pulse: frame complete and checked
//  frame_err out  1          1-cycle pulse: frame aborted
//  err_code  out  2          0 none, 1 checksum, 2 timeout, 3 overrun; valid with frame_err
// BEHAVIOUR
//  Reset: FSM to IDLE, word buffer emptied, timeout counter cleared.
//   All outputs 0. rst mid-frame discards the frame without a frame_err.
//  Word buffer: 1 entry, tracked by byte index 0..DEPTH.
//   - rx_valid with buffer empty: capture the word at that edge; byte [0] is usable the next cycle.
//   - rx_valid in the same cycle the last buffered byte is consumed: accepted, no overrun.
//  Consume: at most one byte per cycle.
//   - Outside PAYLOAD: unconditional.
//   - In PAYLOAD: only on pl_valid && pl_ready.
//  FSM states: IDLE, CMD, LEN, PAYLOAD, CSUM.
//   - IDLE: byte == SYNC_BYTE -> CMD; any other byte is dropped silently.
//   - CMD: latch the byte -> LEN.
//   - LEN: latch len; cmd_valid pulses the next cycle.
//     LEN == 0 -> CSUM, otherwise -> PAYLOAD.
//   - PAYLOAD: pl_valid = buffer non-empty; pl_data = current byte; cut-through, no payload storage.
//     pl_last = 1 on byte number len. After that transfer -> CSUM.
//   - CSUM: compare the byte with the XOR of CMD, LEN and all payload bytes.
//     Match -> frame_ok; mismatch -> frame_err, code 1. Both cases -> IDLE.
//  Unused bytes left in a word after a frame ends are parsed from IDLE.
//  Timeout: the counter clears on every rx_valid and counts while FSM != IDLE and the buffer is empty.
//   Reaching TIMEOUT_CYC: frame_err code 2 -> IDLE.
//  Overrun: rx_valid while unconsumed bytes remain.
//   - The new word and the remaining bytes are discarded.
//   - frame_err code 3. FSM -> IDLE.
//   - If already in IDLE: word discarded and error still reported.
//  Priority in one cycle: rst > overrun > timeout > normal parse.
//  frame_ok, frame_err and cmd_valid are registered; frame_ok and frame_err are never high together.
// CONFIGURATION
//  UART_FRAME_CSUM_EN
//   - Defined: CSUM state present, XOR check as above.
//   - Undefined: no CSUM byte and err_code 1 never occurs.
//     Frame ends after the pl_last transfer, or after LEN when LEN == 0; frame_ok pulses the next cycle.
// STRUCTURE
//  Package uart_frame_pkg: frame_state_t enum, frame_err_t enum (NONE/CSUM/TIMEOUT/OVERRUN), SYNC_BYTE default.
//  Sub-module uart_word_unpacker: word buffer, byte index, empty flag, overrun detection.
//  Top level: FSM, checksum accumulator, timeout counter.
// TESTING
//  T1: words {A5,01,02,10} then {20,33,00,00}, pl_ready = 1
//      -> cmd_valid with cmd 01, len 02; pl_data 10, 20 with pl_last on 20; frame_ok; trailing 00 bytes dropped.
//  T2: same as T1 with CSUM 34 -> frame_err, err_code 1; no frame_ok; payload 10, 20 still delivered.
//  T3: words {A5,07,00,07} -> cmd_valid with cmd 07, len 00; no pl_valid; frame_ok.
//      Without UART_FRAME_CSUM_EN: frame_ok, then the trailing 07 is dropped in IDLE.
//  T4: T1 with pl_ready held 0 until a second rx_valid arrives -> frame_err code 3 the next cycle.
//      A later frame parses correctly.
//  T5: word {A5,01,05,10}, then silence for TIMEOUT_CYC cycles -> frame_err code 2.
//      The following T1 frame is accepted.
//  T6: rst asserted for 1 cycle mid-PAYLOAD -> all outputs 0 and no frame_err; a subsequent T1 frame passes.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// ============================================================================
// Module   : uart_frame_pkg
// Brief    : Shared types and defaults for the UART frame controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } frame_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } frame_err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/uart_word_unpacker.sv
// ============================================================================
// Module   : uart_word_unpacker
// Brief    : One-entry word buffer that hands out bytes, element [0] first,
//            and flags words arriving while bytes are still unconsumed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_unpacker #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH-1:0][7:0] word_i,
    input  logic                  word_valid_i,
    input  logic                  consume_i,
    output logic [7:0]            byte_o,
    output logic                  avail_o,
    output logic                  overrun_o
);

    localparam int              IDX_W     = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_EMPTY = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);

    logic [DEPTH-1:0][7:0] word_q, word_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  w_last_taken;
    logic [7:0]            w_byte;

    assign avail_o      = (idx_q != IDX_EMPTY);
    assign w_last_taken = consume_i && avail_o && (idx_q == IDX_LAST);
    // A word landing on the cycle the final byte leaves is a clean hand-over.
    assign overrun_o    = word_valid_i && avail_o && !w_last_taken;
    assign byte_o       = w_byte;

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_byte = word_q[i];
            end
        end
    end

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (overrun_o) begin
            idx_d = IDX_EMPTY;
        end else if (word_valid_i) begin
            word_d = word_i;
            idx_d  = '0;
        end else if (consume_i && avail_o) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= IDX_EMPTY;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : Parses SYNC/CMD/LEN/payload/CSUM frames from packed UART words
//            and streams the payload over valid/ready. Checksum byte and
//            check are present only when UART_FRAME_CSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 2_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH-1:0][7:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            cmd_o,
    output logic [7:0]            len_o,
    output logic                  cmd_valid_o,
    output logic [7:0]            pl_data_o,
    output logic                  pl_valid_o,
    input  logic                  pl_ready_i,
    output logic                  pl_last_o,
    output logic                  frame_ok_o,
    output logic                  frame_err_o,
    output logic [1:0]            err_code_o
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    frame_state_t    state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      rem_q, rem_d;
    logic [7:0]      csum_q, csum_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    frame_err_t      err_code_q, err_code_d;

    logic [7:0]      w_byte;
    logic            w_avail;
    logic            w_overrun;
    logic            w_take;
    logic            w_pl_valid;
    logic            w_timeout;

    uart_word_unpacker #(
        .DEPTH (DEPTH)
    ) u_unpacker (
        .clk          (clk),
        .rst          (rst),
        .word_i       (rx_data_i),
        .word_valid_i (rx_valid_i),
        .consume_i    (w_take),
        .byte_o       (w_byte),
        .avail_o      (w_avail),
        .overrun_o    (w_overrun)
    );

    assign w_pl_valid = (state_q == ST_PAYLOAD) && w_avail;
    assign w_take     = w_avail && ((state_q != ST_PAYLOAD) || pl_ready_i);
    assign w_timeout  = (state_q != ST_IDLE) && !w_avail && !rx_valid_i
                        && (to_cnt_q == TO_LAST);

    assign cmd_o       = cmd_q;
    assign len_o       = len_q;
    assign cmd_valid_o = cmd_valid_q;
    assign pl_valid_o  = w_pl_valid;
    assign pl_data_o   = w_pl_valid ? w_byte : 8'h00;
    assign pl_last_o   = w_pl_valid && (rem_q == 8'd1);
    assign frame_ok_o  = frame_ok_q;
    assign frame_err_o = frame_err_q;
    assign err_code_o  = err_code_q;

    // Only the wait for the next word is timed; a stalled payload holds the count.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (rx_valid_i || (state_q == ST_IDLE)) begin
            to_cnt_d = '0;
        end else if (!w_avail) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        cmd_valid_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = ERR_NONE;
        if (w_overrun) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVERRUN;
            state_d     = ST_IDLE;
        end else if (w_timeout) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
        end else if (w_take) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_byte == SYNC_BYTE) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    cmd_d   = w_byte;
                    csum_d  = w_byte;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    len_d       = w_byte;
                    rem_d       = w_byte;
                    csum_d      = csum_q ^ w_byte;
                    cmd_valid_d = 1'b1;
                    if (w_byte != 8'd0) begin
                        state_d = ST_PAYLOAD;
                    end else begin
`ifdef UART_FRAME_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d    = ST_IDLE;
                        frame_ok_d = 1'b1;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    csum_d = csum_q ^ w_byte;
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
`ifdef UART_FRAME_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d    = ST_IDLE;
                        frame_ok_d = 1'b1;
`endif
                    end
                end
`ifdef UART_FRAME_CSUM_EN
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (w_byte == csum_q) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            len_q       <= 8'h00;
            rem_q       <= 8'h00;
            csum_q      <= 8'h00;
            to_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            to_cnt_q    <= to_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

endmodule

`default_nettype wire
